// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: data width, funct3 width codes
// and the stage FSM encoding.
package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side issue, data-memory port and writeback signals of the memory stage.
// The stage connects through "slave"; its environment drives through "master".
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] store_val;
    logic [2:0]      funct3;
    logic            is_load;
    logic            is_store;
    logic [4:0]      rd;
    logic            reg_write;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic [XLEN-1:0] wb_val;
    logic            fault;

    modport slave (
        input  in_valid, alu_res, store_val, funct3, is_load, is_store, rd, reg_write,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rd, wb_we, wb_val, fault
    );

    modport master (
        output in_valid, alu_res, store_val, funct3, is_load, is_store, rd, reg_write,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rd, wb_we, wb_val, fault
    );

endinterface

// File: rtl/mem_stage_align.sv
// Byte-lane logic: byte enables, store-data replication, alignment/illegal-width
// fault and load extraction with sign/zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_fault,
    output logic [XLEN-1:0] o_rdata
);

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;
    logic            w_signed;

    assign w_shamt   = {i_addr_lo, 3'b000};
    assign w_shifted = i_rdata >> w_shamt;
    // funct3[2] set means the unsigned (BU/HU) variant
    assign w_signed  = ~i_funct3[2];

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_fault = 1'b0;
        o_rdata = w_shifted;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7] & w_signed}}, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
                o_fault = i_addr_lo[0];
                o_rdata = {{16{w_shifted[15] & w_signed}}, w_shifted[15:0]};
            end
            F3_W: begin
                o_be    = 4'b1111;
                o_fault = |i_addr_lo;
            end
            default: begin
                o_fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one instruction, runs its load/store on the
// request/grant/response port and emits a registered writeback packet.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for an instruction; non-memory ops and faults retire here
//   ST_REQ  | mem_req asserted, request fields held until mem_gnt
//   ST_RESP | load granted, waiting for mem_rvalid
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    mem_stage_if.slave bus
);

    state_e          r_state;
    state_e          w_state_nxt;

    logic [2:0]      r_funct3;
    logic [1:0]      r_addr_lo;
    logic            r_is_load;
    logic [4:0]      r_rd;
    logic            r_reg_write;

    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [3:0]      r_mem_be;
    logic [XLEN-1:0] r_mem_wdata;

    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic            r_wb_we;
    logic [XLEN-1:0] r_wb_val;
    logic            r_fault;

    logic            w_idle;
    logic            w_is_mem;
    logic [2:0]      w_sel_funct3;
    logic [1:0]      w_sel_addr_lo;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_fault;
    logic [XLEN-1:0] w_load_val;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_is_mem = bus.is_load | bus.is_store;

    // Live inputs drive the lane logic at accept; latched fields drive it during RESP.
    assign w_sel_funct3  = w_idle ? bus.funct3       : r_funct3;
    assign w_sel_addr_lo = w_idle ? bus.alu_res[1:0] : r_addr_lo;

    mem_align u_align (
        .i_funct3  (w_sel_funct3),
        .i_addr_lo (w_sel_addr_lo),
        .i_wdata   (bus.store_val),
        .i_rdata   (bus.mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_fault   (w_fault),
        .o_rdata   (w_load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && w_is_mem && !w_fault) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_gnt) begin
                    w_state_nxt = r_is_load ? ST_RESP : ST_IDLE;
                end
            end
            ST_RESP: begin
                if (bus.mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_funct3    <= 3'b000;
            r_addr_lo   <= 2'b00;
            r_is_load   <= 1'b0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_we     <= 1'b0;
            r_wb_val    <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_funct3    <= bus.funct3;
                        r_addr_lo   <= bus.alu_res[1:0];
                        r_is_load   <= bus.is_load;
                        r_rd        <= bus.rd;
                        r_reg_write <= bus.reg_write;
                        if (!w_is_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= bus.rd;
                            r_wb_we    <= bus.reg_write;
                            r_wb_val   <= bus.alu_res;
                            r_fault    <= 1'b0;
                        end else if (w_fault) begin
                            // faulting address is reported in wb_val for diagnosis
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= bus.rd;
                            r_wb_we    <= 1'b0;
                            r_wb_val   <= bus.alu_res;
                            r_fault    <= 1'b1;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.is_store;
                            r_mem_addr  <= {bus.alu_res[XLEN-1:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (!r_is_load) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_we    <= 1'b0;
                            r_fault    <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.mem_rvalid) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_we    <= r_reg_write;
                        r_wb_val   <= w_load_val;
                        r_fault    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_we     = r_wb_we;
    assign bus.wb_val    = r_wb_val;
    assign bus.fault     = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, then random traffic checked
// against a byte-addressed memory model.
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mem_stage_if bus();

    mem_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] val;
        logic        flt;
        logic        chk_val;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
    } mem_exp_t;

    wb_exp_t  wb_q[$];
    mem_exp_t mem_q[$];
    int total = 0;
    int bad = 0;
    bit auto_mem = 1'b0;
    bit abort = 1'b0;

    logic [7:0]  mdl_mem [int unsigned];
    logic [31:0] phys    [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned widx);
        return (widx * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [7:0] mdl_rd(input int unsigned a);
        logic [31:0] w;
        if (mdl_mem.exists(a)) return mdl_mem[a];
        w = init_word(a / 4) >> (8 * (a % 4));
        return w[7:0];
    endfunction

    function automatic logic [31:0] phys_rd(input int unsigned widx);
        if (phys.exists(widx)) return phys[widx];
        return init_word(widx);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic void push_wb(input logic [4:0] rd, input logic we, input logic [31:0] val,
                                    input logic flt, input logic chk_val);
        wb_exp_t e;
        e.rd = rd; e.we = we; e.val = val; e.flt = flt; e.chk_val = chk_val;
        wb_q.push_back(e);
    endfunction

    function automatic void push_mem(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                     input logic [31:0] wd, input logic chk_wd);
        mem_exp_t m;
        m.addr = addr; m.we = we; m.be = be; m.wdata = wd; m.chk_wd = chk_wd;
        mem_q.push_back(m);
    endfunction

    // Reference: byte-granular memory, access size from funct3, little-endian assembly.
    function automatic void model_push(input logic ld, input logic st, input logic [2:0] f3,
                                       input logic [31:0] alu, input logic [31:0] sv,
                                       input logic [4:0] rd, input logic rw);
        int unsigned a = alu;
        int sz;
        int be_int;
        logic [31:0] v;
        logic [31:0] mask;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (!ld && !st) begin
            push_wb(rd, rw, alu, 1'b0, 1'b1);
            return;
        end
        if (sz == 0 || (a % sz) != 0) begin
            push_wb(rd, 1'b0, 32'h0, 1'b1, 1'b0);
            return;
        end
        be_int = ((1 << sz) - 1) << (a % 4);
        v = 32'h0;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = sv[8*(i % sz) +: 8];
        push_mem(a - (a % 4), st, be_int[3:0], v, st);
        if (st) begin
            for (int i = 0; i < sz; i++) mdl_mem[a + i] = sv[8*i +: 8];
            push_wb(rd, 1'b0, 32'h0, 1'b0, 1'b0);
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | ({24'h0, mdl_rd(a + i)} << (8 * i));
            if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) begin
                mask = (32'h1 << (8 * sz)) - 32'h1;
                v = v | ~mask;
            end
            push_wb(rd, rw, v, 1'b0, 1'b1);
        end
    endfunction

    initial begin : monitor
        wb_exp_t  e;
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.wb_valid) begin
                    if (wb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL wb_unexpected: got wb_valid rd=%0d val=0x%08h expected no writeback",
                                 bus.wb_rd, bus.wb_val);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_rd", {27'h0, bus.wb_rd}, {27'h0, e.rd});
                        chk("wb_we", {31'h0, bus.wb_we}, {31'h0, e.we});
                        chk("wb_fault", {31'h0, bus.fault}, {31'h0, e.flt});
                        if (e.chk_val) chk("wb_val", bus.wb_val, e.val);
                    end
                end
                if (bus.mem_req && bus.mem_gnt) begin
                    if (mem_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL mem_unexpected: got request addr=0x%08h expected none", bus.mem_addr);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_addr", bus.mem_addr, m.addr);
                        chk("mem_we", {31'h0, bus.mem_we}, {31'h0, m.we});
                        chk("mem_be", {28'h0, bus.mem_be}, {28'h0, m.be});
                        if (m.chk_wd) chk("mem_wdata", bus.mem_wdata, m.wdata);
                    end
                end
            end
        end
    end

    initial begin : responder
        int d;
        logic [31:0] a, wd, w;
        logic        we;
        logic [3:0]  be;
        forever begin
            @(posedge clk); #1;
            if (auto_mem && bus.mem_req) begin
                d = $urandom_range(0, 3);
                repeat (d) begin @(posedge clk); #1; end
                bus.mem_gnt = 1'b1;
                a = bus.mem_addr; we = bus.mem_we; be = bus.mem_be; wd = bus.mem_wdata;
                @(posedge clk); #1;
                bus.mem_gnt = 1'b0;
                if (we) begin
                    w = phys_rd(a / 4);
                    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
                    phys[a / 4] = w;
                end else begin
                    d = $urandom_range(0, 3);
                    repeat (d) begin bus.mem_rdata = $urandom; @(posedge clk); #1; end
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = phys_rd(a / 4);
                    @(posedge clk); #1;
                    bus.mem_rvalid = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sv, input logic [4:0] rd, input logic rw);
        int n = 0;
        while (!bus.in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL issue_timeout: in_ready 0 for %0d cycles, expected 1", n);
                abort = 1'b1;
                return;
            end
        end
        bus.is_load = ld; bus.is_store = st; bus.funct3 = f3; bus.alu_res = alu;
        bus.store_val = sv; bus.rd = rd; bus.reg_write = rw; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_gnt(input int n);
        logic [31:0] a0 = bus.mem_addr;
        repeat (n) begin
            chk("req_held", {31'h0, bus.mem_req}, 32'h1);
            chk("addr_held", bus.mem_addr, a0);
            @(posedge clk); #1;
        end
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        chk("req_drop", {31'h0, bus.mem_req}, 32'h0);
    endtask

    task automatic do_rvalid(input logic [31:0] data, input int n);
        repeat (n) begin @(posedge clk); #1; end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = data;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("load_wb_pulse", {31'h0, bus.wb_valid}, 32'h1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2:0] legal [5];
        logic [2:0] illegal [3];
        logic [2:0] f3;
        int kind, r, n;
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        illegal = '{3'd3, 3'd6, 3'd7};

        bus.in_valid = 0; bus.alu_res = 0; bus.store_val = 0; bus.funct3 = 0;
        bus.is_load = 0; bus.is_store = 0; bus.rd = 0; bus.reg_write = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
        chk("rst_wb_we", {31'h0, bus.wb_we}, 32'h0);
        chk("rst_wb_rd", {27'h0, bus.wb_rd}, 32'h0);
        chk("rst_wb_val", bus.wb_val, 32'h0);
        chk("rst_fault", {31'h0, bus.fault}, 32'h0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        push_wb(5'd5, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        chk("add_wb_t1", {31'h0, bus.wb_valid}, 32'h1);
        chk("add_no_req", {31'h0, bus.mem_req}, 32'h0);
        @(posedge clk); #1;
        chk("add_pulse_end", {31'h0, bus.wb_valid}, 32'h0);

        push_mem(32'h100, 1'b1, 4'b1000, 32'hDDDD_DDDD, 1'b1);
        push_wb(5'd7, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'd0, 32'h103, 32'hAABB_CCDD, 5'd7, 1'b1);
        chk("sb_req", {31'h0, bus.mem_req}, 32'h1);
        do_gnt(2);
        chk("sb_wb", {31'h0, bus.wb_valid}, 32'h1);

        push_mem(32'h100, 1'b0, 4'b0100, 32'h0, 1'b0);
        push_wb(5'd9, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 5'd9, 1'b1);
        do_gnt(0);
        do_rvalid(32'h0080_0000, 1);

        push_mem(32'h100, 1'b0, 4'b0100, 32'h0, 1'b0);
        push_wb(5'd10, 1'b1, 32'h0000_0080, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 5'd10, 1'b1);
        do_gnt(1);
        do_rvalid(32'h0080_0000, 0);

        push_mem(32'h100, 1'b0, 4'b1100, 32'h0, 1'b0);
        push_wb(5'd11, 1'b1, 32'h0000_8001, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 5'd11, 1'b1);
        do_gnt(0);
        do_rvalid(32'h8001_0000, 2);

        push_mem(32'h100, 1'b0, 4'b1100, 32'h0, 1'b0);
        push_wb(5'd12, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 5'd12, 1'b1);
        do_gnt(0);
        do_rvalid(32'h8001_0000, 0);

        push_wb(5'd3, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 3'd2, 32'h206, 32'h0, 5'd3, 1'b1);
        chk("lw_mis_no_req", {31'h0, bus.mem_req}, 32'h0);
        chk("lw_mis_wb", {31'h0, bus.wb_valid}, 32'h1);
        chk("lw_mis_fault", {31'h0, bus.fault}, 32'h1);

        push_wb(5'd4, 1'b0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 3'd3, 32'h200, 32'h0, 5'd4, 1'b1);
        chk("f3_011_no_req", {31'h0, bus.mem_req}, 32'h0);
        chk("f3_011_fault", {31'h0, bus.fault}, 32'h1);

        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("stray_rvalid_idle", {31'h0, bus.in_ready}, 32'h1);
        chk("stray_rvalid_no_wb", {31'h0, bus.wb_valid}, 32'h0);

        push_mem(32'h40, 1'b1, 4'b1111, 32'h1122_3344, 1'b1);
        push_wb(5'd2, 1'b0, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'd2, 32'h40, 32'h1122_3344, 5'd2, 1'b1);
        do_gnt(5);
        chk("sw_wb", {31'h0, bus.wb_valid}, 32'h1);

        issue(1'b1, 1'b0, 3'd2, 32'h80, 32'h0, 5'd4, 1'b1);
        chk("rstreq_req_up", {31'h0, bus.mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstreq_req_drop", {31'h0, bus.mem_req}, 32'h0);
        chk("rstreq_idle", {31'h0, bus.in_ready}, 32'h1);
        bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_gnt = 1'b0;
        @(posedge clk); #1;
        chk("rstreq_after", {31'h0, bus.in_ready}, 32'h1);

        push_mem(32'h80, 1'b0, 4'b1100, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'd1, 32'h82, 32'h0, 5'd6, 1'b1);
        do_gnt(0);
        chk("resp_busy", {31'h0, bus.in_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstresp_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rstresp_idle", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("rstresp_no_wb", {31'h0, bus.wb_valid}, 32'h0);
        chk("rstresp_ready", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk); #1;

        auto_mem = 1'b1;
        for (int k = 0; k < 400 && !abort; k++) begin
            kind = $urandom_range(0, 2);
            r = $urandom_range(0, 15);
            f3 = (r < 13) ? legal[r % 5] : illegal[r % 3];
            if (kind == 0) begin
                bus.alu_res = $urandom;
                model_push(1'b0, 1'b0, f3, bus.alu_res, 32'h0, 5'($urandom_range(0, 31)), 1'b1);
                issue(1'b0, 1'b0, f3, wb_q[$].val, 32'h0, wb_q[$].rd, 1'b1);
            end else begin
                logic [31:0] addr, sv;
                logic [4:0]  rd;
                logic        rw;
                addr = 32'h1000 + 32'($urandom_range(0, 31));
                sv = $urandom;
                rd = 5'($urandom_range(0, 31));
                rw = 1'($urandom_range(0, 1));
                model_push(kind == 1, kind == 2, f3, addr, sv, rd, rw);
                issue(kind == 1, kind == 2, f3, addr, sv, rd, rw);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        n = 0;
        while (wb_q.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_wb_q", wb_q.size(), 32'h0);
        chk("drain_mem_q", mem_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage directly downstream of the execute-stage ALU. Takes the ALU result (effective address or plain result) plus store data and destination info. Runs one load or store per instruction on a request/grant/response data-memory port with byte-lane alignment and load sign/zero extension. Presents a registered writeback packet to the register file.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage offers an instruction this cycle
- in_ready  out  1  stage can accept; high only in IDLE
- alu_res  in  32  ALU result; effective address for loads/stores
- store_val  in  32  rs2 value for stores
- funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- is_load, is_store  in  1 each  memory op select; never both high
- rd  in  5  destination register
- reg_write  in  1  instruction writes rd
- mem_req  out  1  data-memory request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address (alu_res with [1:0] = 0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  5  destination register
- wb_we  out  1  register write enable
- wb_val  out  32  writeback value
- fault  out  1  qualifies wb_valid: misaligned or illegal funct3

## Operation
- States: IDLE, REQ, RESP.
- IDLE, in_valid high: latch all inputs. Then:
  - Non-memory op: stay IDLE; wb packet = alu_res, reg_write.
  - Memory op with fault: stay IDLE; no request; wb_we = 0, fault = 1.
  - Otherwise: go to REQ.
- Fault conditions: H/HU with addr[0] = 1; W with addr[1:0] != 0; funct3 011, 110 or 111 on a memory op.
- REQ: mem_req = 1; address, we, be and wdata are stable until mem_gnt.
  - Store: on gnt, go to IDLE; wb packet has wb_we = 0.
  - Load: on gnt, go to RESP.
- RESP: wait for mem_rvalid. Then go to IDLE; wb_val = extracted load value; wb_we = latched reg_write.
- mem_rvalid is ignored outside RESP. The memory must not assert rvalid in its gnt cycle.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- Store data: B replicates the byte to all four lanes; H replicates the halfword to both halves; W passes through.
- Load extraction: rdata >> (8*addr[1:0]), then B/H sign-extend from bit 7/15 and BU/HU zero-extend.
- rd = 0 is passed through unchanged; the register file discards it.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, wb_valid 0, wb_we 0, wb_rd 0, wb_val 0, fault 0.
- in_ready is combinational: equals (state == IDLE).
- Let T0 be the accept edge:
  - Non-memory op or fault: wb_valid high in cycle T0+1, for exactly one cycle.
  - Store: mem_req high from T0+1. Gnt at Tg gives wb_valid in Tg+1. Minimum latency 2.
  - Load: rvalid at Tr (≥ Tg+1) gives wb_valid in Tr+1. Minimum latency 3.
- Back-to-back: a non-memory op can be accepted every cycle. wb_valid may be high on consecutive cycles.
- mem_req is registered and deasserts the cycle after gnt.
- Reset mid-operation: state returns to IDLE and mem_req drops immediately (asynchronous). Any pending gnt or rvalid is ignored. No wb_valid is produced for the aborted instruction.
- wb outputs hold their last value between pulses; only wb_valid qualifies them.

## Structure
- Shared package holds the funct3 width codes, the state encoding (IDLE/REQ/RESP) and XLEN = 32.
- One combinational sub-module, mem_align, computes be, replicated wdata, the fault flag and load extraction/extension from (funct3, addr[1:0], data).
- The top level holds the FSM, the input latch and the wb registers.

## Test plan
- ADD result 0x0000_1234, reg_write = 1, rd = 5 → wb_valid at T0+1: wb_val 0x1234, wb_we 1, wb_rd 5, fault 0; no mem_req.
- SB, addr 0x103, store_val 0xAABBCCDD, gnt after 2 cycles → mem_addr 0x100, be 1000, wdata 0xDDDDDDDD; wb_valid one cycle after gnt, wb_we 0.
- LB, addr 0x102, rdata 0x0080_0000 → wb_val 0xFFFF_FF80. LBU at the same address and data → 0x0000_0080. LHU, addr 0x102, rdata 0x8001_0000 → 0x0000_8001.
- LW at addr 0x206 → no mem_req; wb_valid at T0+1 with fault 1, wb_we 0. Funct3 011 on a load → same response.
- Load in RESP, rst_n pulsed low, then rvalid arrives → mem_req low during reset, state IDLE, no wb_valid, in_ready 1.
- Stray mem_rvalid while IDLE, and gnt held low 5 cycles in REQ → no state change on the stray rvalid; mem_req and mem_addr stay stable for all 5 cycles.
